plugin_mem_arbiter: RTL and testbench
=====================================

# plugin_mem_arbiter

Two-requester arbiter that shares the single-port data RAM between the RS5 core data port and the image-plugin memory master. It sits between `plugin_image_memory_interface` and the data RAM, and gives the CPU priority. A starvation counter guarantees the plugin forward progress. Plugin accesses outside a configured RAM window are rejected with a sticky error and do not touch memory.

## Interface
- MEM_BASE, 32'h0000_0000, first byte address the plugin may access
- MEM_SIZE, 32'h0010_0000, size in bytes of the plugin-accessible window
- MAX_WAIT, 4, consecutive lost arbitration cycles before the plugin is forced through (≥1)

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_en_i  in  1  CPU data access request; held while cpu_stall_o is high
- cpu_we_i  in  4  CPU byte write enables; 0 means read
- cpu_addr_i  in  32  CPU byte address
- cpu_wdata_i  in  32  CPU write data
- cpu_rdata_o  out  32  read data, valid one cycle after the CPU grant
- cpu_stall_o  out  1  CPU request not accepted this cycle
- plg_req_i  in  1  plugin request; held stable until plg_ready_o
- plg_we_i  in  1  plugin word write
- plg_addr_i  in  32  plugin byte address; bits [1:0] ignored
- plg_wdata_i  in  32  plugin write data
- plg_rdata_o  out  32  plugin read data, valid while plg_ready_o is high, else 0
- plg_ready_o  out  1  one-cycle completion pulse
- mem_en_o  out  1  RAM enable
- mem_we_o  out  4  RAM byte enables
- mem_addr_o  out  32  RAM address
- mem_wdata_o  out  32  RAM write data
- mem_rdata_i  in  32  RAM read data, one-cycle latency
- err_o  out  1  sticky: plugin accessed outside the window
- err_clr_i  in  1  clears err_o
- stall_cnt_o  out  32  count of CPU stall cycles, wraps

## Operation
- plg_pending = plg_req_i && !plg_outstanding. plg_outstanding is set for the cycle after a plugin issue, which masks the still-held request during its response cycle.
- plg_in_win = (plg_addr_i − MEM_BASE) < MEM_SIZE. This is an unsigned 32-bit compare, so addresses below MEM_BASE wrap and fail.
- force = (wait_cnt == MAX_WAIT).
- Grant priority in each cycle:
  1. If plg_pending, plg_in_win and (force or !cpu_en_i): grant the plugin.
  2. Else if cpu_en_i: grant the CPU.
  3. Else: idle.
- An out-of-window plg_pending never drives memory and does not block the CPU grant in the same cycle. In the next cycle: plg_ready_o=1, plg_rdata_o=0, err_o set.
- Plugin grant drives: mem_en_o=1, mem_we_o = plg_we_i ? 4'hF : 4'h0, mem_addr_o = {plg_addr_i[31:2], 2'b00}, mem_wdata_o = plg_wdata_i.
- CPU grant passes cpu_en_i, cpu_we_i, cpu_addr_i and cpu_wdata_i straight through.
- Idle drives all mem_* outputs to 0.
- cpu_stall_o = cpu_en_i && plugin granted.
- wait_cnt (width $clog2(MAX_WAIT+1)):
  - clears on any plugin completion, in-window or error;
  - increments, saturating, when plg_pending && plg_in_win && CPU granted;
  - otherwise holds.
- A resp_owner register (NONE/CPU/PLG/ERR) records the previous cycle's grant and routes mem_rdata_i:
  - PLG: drives plg_rdata_o and plg_ready_o=1;
  - CPU: drives cpu_rdata_o;
  - otherwise: cpu_rdata_o holds its last value.
- stall_cnt_o increments on every cycle with cpu_stall_o high.
- err_o: err_clr_i takes priority over a new error in the same cycle.

## Timing
- Arbitration and mem_* outputs are combinational from the request inputs and registered state. There is no added request latency.
- Read latency is 1 cycle for both requesters. For a plugin access, issue in cycle N gives plg_ready_o in N+1, for reads and writes alike.
- Plugin throughput is at most one access per 2 cycles. The next request is accepted no earlier than N+2.
- The CPU can be granted in N+1 while the plugin response is returned; the RAM is pipelined.
- Worst-case plugin wait under continuous CPU traffic is MAX_WAIT cycles, then one forced grant.
- Reset values:
  - resp_owner=NONE, plg_outstanding=0, wait_cnt=0;
  - plg_ready_o=0, plg_rdata_o=0, cpu_rdata_o=0, err_o=0, stall_cnt_o=0.
- Reset asserted mid-access: the outstanding response is dropped and no plg_ready_o is issued after reset. The plugin must re-request.

## Structure
- RS5_pkg holds typedef enum logic [1:0] {OWNER_NONE, OWNER_CPU, OWNER_PLG, OWNER_ERR} mem_owner_e.
- RS5_pkg also holds PLUGIN_MEM_BASE and PLUGIN_MEM_SIZE defaults.
- Single module, no sub-module. The saturating counter and owner register are inline.

## Test plan
- Plugin read only, addr 0x100, RAM[0x40]=0xDEADBEEF:
  - cycle N: mem_en_o=1, mem_addr_o=0x100;
  - N+1: plg_ready_o=1, plg_rdata_o=0xDEADBEEF;
  - no reissue in N+1.
- Simultaneous CPU read 0x200 and plugin write 0x300, wait_cnt=0: CPU granted, cpu_stall_o=0, wait_cnt→1.
- Continuous CPU requests with MAX_WAIT=4 and a plugin write pending:
  - CPU granted for 4 cycles;
  - 5th cycle: plugin granted and cpu_stall_o=1;
  - next cycle: plg_ready_o=1 and the CPU is granted;
  - stall_cnt_o=1.
- Plugin read at 0x0010_0000 (MEM_SIZE default) with a concurrent CPU read:
  - CPU granted and mem_addr_o equals the CPU address;
  - next cycle: plg_ready_o=1, plg_rdata_o=0, err_o=1;
  - pulse err_clr_i: err_o=0.
- Plugin byte write addr 0x103: mem_addr_o=0x100, mem_we_o=4'hF.
- Assert reset_n low in the cycle after a plugin grant: plg_ready_o is 0, and all counters and err_o are 0 after release.

Source files
------------

// File: rtl/RS5_pkg.sv
// Shared types and defaults for the RS5 data-memory subsystem.
//   mem_owner_e     : which requester owns the RAM response in the current cycle
//   PLUGIN_MEM_BASE : default first byte address of the plugin-accessible window
//   PLUGIN_MEM_SIZE : default size in bytes of the plugin-accessible window
package RS5_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_CPU,
    OWNER_PLG,
    OWNER_ERR
  } mem_owner_e;

  localparam logic [31:0] PLUGIN_MEM_BASE = 32'h0000_0000;
  localparam logic [31:0] PLUGIN_MEM_SIZE = 32'h0010_0000;

endpackage

// File: rtl/plugin_mem_arbiter.sv
// Shares the single-port data RAM between the CPU data port and the image-plugin
// memory master. The CPU has priority; a saturating wait counter forces one plugin
// grant after MAX_WAIT lost cycles. Plugin accesses outside the window are answered
// with a zero-data completion and a sticky error, without touching memory.
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   cpu_*                    : CPU data port (request, stall, read data)
//   plg_*                    : plugin master (request held until plg_ready_o pulse)
//   mem_*                    : RAM port, one-cycle read latency
//   err_o / err_clr_i        : sticky out-of-window error and its clear
//   stall_cnt_o              : wrapping count of CPU stall cycles
module plugin_mem_arbiter
  import RS5_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = PLUGIN_MEM_BASE,
  parameter logic [31:0] MEM_SIZE = PLUGIN_MEM_SIZE,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_en_i,
  input  logic [3:0]  cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  input  logic        plg_req_i,
  input  logic        plg_we_i,
  input  logic [31:0] plg_addr_i,
  input  logic [31:0] plg_wdata_i,
  output logic [31:0] plg_rdata_o,
  output logic        plg_ready_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [31:0] stall_cnt_o
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  mem_owner_e       resp_owner_q, resp_owner_d;
  logic             plg_outstanding_q, plg_outstanding_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;

  logic plg_pending, plg_in_win, force_grant, plg_gnt, plg_err, cpu_gnt;

  always_comb begin
    plg_pending = plg_req_i && !plg_outstanding_q;
    // Unsigned wrap makes addresses below MEM_BASE fall outside the window.
    plg_in_win  = (plg_addr_i - MEM_BASE) < MEM_SIZE;
    force_grant = (wait_cnt_q == WaitMax);
    plg_gnt     = plg_pending && plg_in_win && (force_grant || !cpu_en_i);
    plg_err     = plg_pending && !plg_in_win;
    cpu_gnt     = cpu_en_i && !plg_gnt;

    mem_en_o    = 1'b0;
    mem_we_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (plg_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = plg_we_i ? 4'hF : 4'h0;
      mem_addr_o  = {plg_addr_i[31:2], 2'b00};
      mem_wdata_o = plg_wdata_i;
    end else if (cpu_gnt) begin
      mem_en_o    = cpu_en_i;
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end

    cpu_stall_o = cpu_en_i && plg_gnt;

    // An error response and a CPU grant can share a cycle, so the plugin completion
    // is tracked by plg_outstanding rather than by the owner alone.
    if (plg_gnt) begin
      resp_owner_d = OWNER_PLG;
    end else if (cpu_gnt) begin
      resp_owner_d = OWNER_CPU;
    end else if (plg_err) begin
      resp_owner_d = OWNER_ERR;
    end else begin
      resp_owner_d = OWNER_NONE;
    end
    plg_outstanding_d = plg_gnt || plg_err;

    plg_ready_o = plg_outstanding_q;
    plg_rdata_o = (resp_owner_q == OWNER_PLG) ? mem_rdata_i : 32'h0;
    cpu_rdata_o = (resp_owner_q == OWNER_CPU) ? mem_rdata_i : cpu_rdata_q;
    cpu_rdata_d = cpu_rdata_o;

    wait_cnt_d = wait_cnt_q;
    if (plg_outstanding_q) begin
      wait_cnt_d = '0;
    end else if (plg_pending && plg_in_win && cpu_gnt && !force_grant) begin
      wait_cnt_d = wait_cnt_q + WaitW'(1);
    end

    stall_cnt_d = cpu_stall_o ? stall_cnt_q + 32'd1 : stall_cnt_q;
    stall_cnt_o = stall_cnt_q;

    if (err_clr_i) begin
      err_d = 1'b0;
    end else if (plg_err) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    err_o = err_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_owner_q      <= OWNER_NONE;
      plg_outstanding_q <= 1'b0;
      wait_cnt_q        <= '0;
      cpu_rdata_q       <= 32'h0;
      stall_cnt_q       <= 32'h0;
      err_q             <= 1'b0;
    end else begin
      resp_owner_q      <= resp_owner_d;
      plg_outstanding_q <= plg_outstanding_d;
      wait_cnt_q        <= wait_cnt_d;
      cpu_rdata_q       <= cpu_rdata_d;
      stall_cnt_q       <= stall_cnt_d;
      err_q             <= err_d;
    end
  end

endmodule

// File: tb/tb_plugin_mem_arbiter.sv
// Directed table-driven bench for plugin_mem_arbiter with a one-cycle-latency RAM model.
module tb_plugin_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_en_i = 1'b0;
  logic [3:0]  cpu_we_i = 4'h0;
  logic [31:0] cpu_addr_i = 32'h0;
  logic [31:0] cpu_wdata_i = 32'h0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        plg_req_i = 1'b0;
  logic        plg_we_i = 1'b0;
  logic [31:0] plg_addr_i = 32'h0;
  logic [31:0] plg_wdata_i = 32'h0;
  logic [31:0] plg_rdata_o;
  logic        plg_ready_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        err_o;
  logic        err_clr_i = 1'b0;
  logic [31:0] stall_cnt_o;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  plugin_mem_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_en_i    (cpu_en_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .plg_req_i   (plg_req_i),
    .plg_we_i    (plg_we_i),
    .plg_addr_i  (plg_addr_i),
    .plg_wdata_i (plg_wdata_i),
    .plg_rdata_o (plg_rdata_o),
    .plg_ready_o (plg_ready_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i),
    .stall_cnt_o (stall_cnt_o)
  );

  // RAM model: word-indexed, read-before-write, one-cycle read latency.
  logic [31:0] ram [0:1023];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_idx = 10'h0;
  logic [31:0] ld_data = 32'h0;

  always @(posedge clk) begin
    if (ld_en) begin
      ram[ld_idx] <= ld_data;
    end else if (mem_en_o) begin
      mem_rdata_i <= ram[mem_addr_o[11:2]];
      for (int b = 0; b < 4; b++) begin
        if (mem_we_o[b]) ram[mem_addr_o[11:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        cpu_en;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        plg_req;
    logic        plg_we;
    logic [31:0] plg_addr;
    logic [31:0] plg_wdata;
    logic        err_clr;
    logic        x_en;
    logic [3:0]  x_we;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_stall;
    logic [31:0] x_crd;
    logic        x_rdy;
    logic [31:0] x_prd;
    logic        x_err;
    logic [31:0] x_sc;
  } vec_t;

  vec_t vecs [23];

  task automatic drive(input vec_t v);
    cpu_en_i = v.cpu_en;  cpu_we_i = v.cpu_we;  cpu_addr_i = v.cpu_addr;
    cpu_wdata_i = v.cpu_wdata;  plg_req_i = v.plg_req;  plg_we_i = v.plg_we;
    plg_addr_i = v.plg_addr;  plg_wdata_i = v.plg_wdata;  err_clr_i = v.err_clr;
  endtask

  task automatic idle_inputs();
    cpu_en_i = 1'b0;  cpu_we_i = 4'h0;  cpu_addr_i = 32'h0;  cpu_wdata_i = 32'h0;
    plg_req_i = 1'b0;  plg_we_i = 1'b0;  plg_addr_i = 32'h0;  plg_wdata_i = 32'h0;
    err_clr_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int found;
  logic [9:0]  pre_idx [7];
  logic [31:0] pre_dat [7];

  initial begin
    // Fields: cpu_en we addr wdata | plg_req we addr wdata | clr ||
    //         exp en we addr wdata stall cpu_rdata rdy plg_rdata err stall_cnt
    vecs[0]  = '{0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0,
                 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0};
    vecs[1]  = '{0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h100, 32'h0, 0,
                 1, 4'h0, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0};
    vecs[2]  = '{0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h100, 32'h0, 0,
                 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1, 32'hDEADBEEF, 0, 0};
    vecs[3]  = '{0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0,
                 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0};
    vecs[4]  = '{1, 4'h0, 32'h200, 32'h0, 1, 1, 32'h300, 32'h55AA55AA, 0,
                 1, 4'h0, 32'h200, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0};
    vecs[5]  = '{1, 4'h0, 32'h204, 32'h0, 1, 1, 32'h300, 32'h55AA55AA, 0,
                 1, 4'h0, 32'h204, 32'h0, 0, 32'h12345678, 0, 32'h0, 0, 0};
    vecs[6]  = '{1, 4'h0, 32'h208, 32'h0, 1, 1, 32'h300, 32'h55AA55AA, 0,
                 1, 4'h0, 32'h208, 32'h0, 0, 32'h11111111, 0, 32'h0, 0, 0};
    vecs[7]  = '{1, 4'h0, 32'h20C, 32'h0, 1, 1, 32'h300, 32'h55AA55AA, 0,
                 1, 4'h0, 32'h20C, 32'h0, 0, 32'h22222222, 0, 32'h0, 0, 0};
    vecs[8]  = '{1, 4'h0, 32'h20C, 32'h0, 1, 1, 32'h300, 32'h55AA55AA, 0,
                 1, 4'hF, 32'h300, 32'h55AA55AA, 1, 32'h33333333, 0, 32'h0, 0, 0};
    vecs[9]  = '{1, 4'h0, 32'h20C, 32'h0, 1, 1, 32'h300, 32'h55AA55AA, 0,
                 1, 4'h0, 32'h20C, 32'h0, 0, 32'h33333333, 1, 32'h0, 0, 1};
    vecs[10] = '{0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0,
                 0, 4'h0, 32'h0, 32'h0, 0, 32'h33333333, 0, 32'h0, 0, 1};
    vecs[11] = '{1, 4'h0, 32'h200, 32'h0, 1, 0, 32'h0010_0000, 32'h0, 0,
                 1, 4'h0, 32'h200, 32'h0, 0, 32'h33333333, 0, 32'h0, 0, 1};
    vecs[12] = '{0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0010_0000, 32'h0, 0,
                 0, 4'h0, 32'h0, 32'h0, 0, 32'h12345678, 1, 32'h0, 1, 1};
    vecs[13] = '{0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1,
                 0, 4'h0, 32'h0, 32'h0, 0, 32'h12345678, 0, 32'h0, 1, 1};
    vecs[14] = '{0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0,
                 0, 4'h0, 32'h0, 32'h0, 0, 32'h12345678, 0, 32'h0, 0, 1};
    vecs[15] = '{0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h103, 32'hCAFEF00D, 0,
                 1, 4'hF, 32'h100, 32'hCAFEF00D, 0, 32'h12345678, 0, 32'h0, 0, 1};
    vecs[16] = '{0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h103, 32'hCAFEF00D, 0,
                 0, 4'h0, 32'h0, 32'h0, 0, 32'h12345678, 1, 32'hDEADBEEF, 0, 1};
    vecs[17] = '{0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0,
                 0, 4'h0, 32'h0, 32'h0, 0, 32'h12345678, 0, 32'h0, 0, 1};
    vecs[18] = '{0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h100, 32'h0, 0,
                 1, 4'h0, 32'h100, 32'h0, 0, 32'h12345678, 0, 32'h0, 0, 1};
    vecs[19] = '{0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h100, 32'h0, 0,
                 0, 4'h0, 32'h0, 32'h0, 0, 32'h12345678, 1, 32'hCAFEF00D, 0, 1};
    vecs[20] = '{1, 4'h3, 32'h208, 32'hAABBCCDD, 0, 0, 32'h0, 32'h0, 0,
                 1, 4'h3, 32'h208, 32'hAABBCCDD, 0, 32'h12345678, 0, 32'h0, 0, 1};
    vecs[21] = '{1, 4'h0, 32'h208, 32'h0, 0, 0, 32'h0, 32'h0, 0,
                 1, 4'h0, 32'h208, 32'h0, 0, 32'h22222222, 0, 32'h0, 0, 1};
    vecs[22] = '{0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0,
                 0, 4'h0, 32'h0, 32'h0, 0, 32'h2222CCDD, 0, 32'h0, 0, 1};

    pre_idx = '{10'h040, 10'h080, 10'h081, 10'h082, 10'h083, 10'h0C0, 10'h0C1};
    pre_dat = '{32'hDEADBEEF, 32'h12345678, 32'h11111111, 32'h22222222, 32'h33333333,
                32'h0, 32'h0};

    // Preload the RAM while the DUT is held in reset.
    next_cycle();
    ld_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ld_idx = pre_idx[i];
      ld_data = pre_dat[i];
      next_cycle();
    end
    ld_en = 1'b0;
    mem_rdata_i = 32'h0;
    next_cycle();
    reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d mem_en", i), {31'h0, mem_en_o}, {31'h0, vecs[i].x_en});
      check($sformatf("v%0d mem_we", i), {28'h0, mem_we_o}, {28'h0, vecs[i].x_we});
      check($sformatf("v%0d mem_addr", i), mem_addr_o, vecs[i].x_addr);
      check($sformatf("v%0d mem_wdata", i), mem_wdata_o, vecs[i].x_wdata);
      check($sformatf("v%0d cpu_stall", i), {31'h0, cpu_stall_o}, {31'h0, vecs[i].x_stall});
      check($sformatf("v%0d cpu_rdata", i), cpu_rdata_o, vecs[i].x_crd);
      check($sformatf("v%0d plg_ready", i), {31'h0, plg_ready_o}, {31'h0, vecs[i].x_rdy});
      check($sformatf("v%0d plg_rdata", i), plg_rdata_o, vecs[i].x_prd);
      check($sformatf("v%0d err", i), {31'h0, err_o}, {31'h0, vecs[i].x_err});
      check($sformatf("v%0d stall_cnt", i), stall_cnt_o, vecs[i].x_sc);
      next_cycle();
    end

    // Out-of-window plugin access with no CPU traffic.
    idle_inputs();
    plg_req_i = 1'b1;
    plg_addr_i = 32'h0020_0000;
    @(negedge clk);
    check("err_solo mem_en", {31'h0, mem_en_o}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("err_solo ready", {31'h0, plg_ready_o}, 32'h1);
    check("err_solo err", {31'h0, err_o}, 32'h1);
    check("err_solo rdata", plg_rdata_o, 32'h0);
    next_cycle();
    plg_req_i = 1'b0;
    next_cycle();

    // Reset in the cycle after a plugin grant drops the response.
    plg_req_i = 1'b1;
    plg_addr_i = 32'h100;
    @(negedge clk);
    check("rst_seq grant", {31'h0, mem_en_o}, 32'h1);
    next_cycle();
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_seq ready", {31'h0, plg_ready_o}, 32'h0);
    check("rst_seq err", {31'h0, err_o}, 32'h0);
    check("rst_seq stall_cnt", stall_cnt_o, 32'h0);
    check("rst_seq cpu_rdata", cpu_rdata_o, 32'h0);
    plg_req_i = 1'b0;
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("rst_seq post ready", {31'h0, plg_ready_o}, 32'h0);
    check("rst_seq post err", {31'h0, err_o}, 32'h0);
    next_cycle();

    // Starvation after reset: wait_cnt must restart from zero.
    cpu_en_i = 1'b1;
    cpu_addr_i = 32'h200;
    plg_req_i = 1'b1;
    plg_we_i = 1'b1;
    plg_addr_i = 32'h304;
    found = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_stall_o) begin
        found = i;
        break;
      end
      next_cycle();
    end
    check("force cycle", found, 32'd4);
    check("force addr", mem_addr_o, 32'h304);
    next_cycle();
    @(negedge clk);
    check("force ready", {31'h0, plg_ready_o}, 32'h1);
    check("force cpu regrant", {31'h0, cpu_stall_o}, 32'h0);
    check("force stall_cnt", stall_cnt_o, 32'h1);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
